uart_alu_interface: RTL and testbench
=====================================

Name: uart_alu_interface

Overview:
Sits directly downstream of the UART receiver. It collects a three-byte command frame from the receiver's data/done-tick outputs: operand A, then operand B, then opcode. It drives those registered operands to the ALU, captures the ALU result, and hands it to the UART transmitter with a one-cycle start pulse. It then waits for the transmitter's done tick before accepting the next frame. An inter-byte timeout resynchronises the frame when the host stalls mid-frame.

Parameters:
NB_DATA, 8, width of UART data bytes, ALU operands and ALU result.
NB_OP, 6, opcode width; taken from the received opcode byte bits [NB_OP-1:0].
TIMEOUT_CYCLES, 1000000, clock cycles allowed between bytes of one frame; 0 disables the timeout.

Ports:
i_clk  input  1  system clock; all state changes on its rising edge.
i_reset  input  1  synchronous, active-high reset.
i_rx_data  input  NB_DATA  received byte from the UART receiver; valid when i_rx_done_tick=1.
i_rx_done_tick  input  1  one-cycle pulse from the receiver marking a new byte.
i_alu_result  input  NB_DATA  combinational ALU result for the current o_data_a/o_data_b/o_op.
i_tx_done_tick  input  1  one-cycle pulse from the transmitter when its stop bit completes.
o_data_a  output  NB_DATA  registered operand A to the ALU.
o_data_b  output  NB_DATA  registered operand B to the ALU.
o_op  output  NB_OP  registered opcode to the ALU.
o_tx_data  output  NB_DATA  registered byte for the transmitter.
o_tx_start  output  1  registered one-cycle start pulse to the transmitter.
o_busy  output  1  high in EXEC, SEND and WAIT_TX.
o_timeout  output  1  registered one-cycle pulse when a frame is abandoned by timeout.
o_rx_overrun  output  1  registered one-cycle pulse when a byte arrives while busy.

Behaviour:
- Reset: state=WAIT_A; o_data_a, o_data_b, o_op, o_tx_data = 0; o_tx_start, o_timeout, o_rx_overrun = 0; timeout counter = 0. Reset mid-frame or mid-transmit aborts immediately; no o_tx_start is emitted afterwards.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A:
  - i_rx_done_tick -> o_data_a <= i_rx_data; go to WAIT_B; counter cleared.
  - No timeout runs in this state.
- WAIT_B:
  - Tick -> o_data_b <= i_rx_data; go to WAIT_OP; counter cleared.
- WAIT_OP:
  - Tick -> o_op <= i_rx_data[NB_OP-1:0]; go to EXEC.
- Timeout (WAIT_B and WAIT_OP only):
  - Counter increments every clock with no tick.
  - When counter == TIMEOUT_CYCLES-1 with no tick that cycle -> go to WAIT_A; o_timeout=1 for one cycle; counter cleared.
  - o_data_a/o_data_b/o_op keep their values.
  - A tick on the expiry cycle wins: the byte is captured and no timeout occurs.
  - With TIMEOUT_CYCLES=0 the counter never expires.
- EXEC: gives the ALU one full cycle to settle on the new operands. At the next edge: o_tx_data <= i_alu_result; o_tx_start <= 1; go to SEND.
- SEND: o_tx_start is high for exactly this one cycle. Next edge: o_tx_start <= 0; go to WAIT_TX.
- WAIT_TX: i_tx_done_tick -> go to WAIT_A. i_tx_done_tick in any other state is ignored.
- Latency:
  - Opcode tick sampled at edge N -> state is EXEC after N.
  - o_tx_data is valid and o_tx_start=1 after edge N+1.
  - o_tx_start falls at edge N+2.
- Overrun: i_rx_done_tick while in EXEC, SEND or WAIT_TX -> byte discarded; o_rx_overrun=1 for one cycle; state unaffected.
- Simultaneous i_tx_done_tick and i_rx_done_tick in WAIT_TX -> go to WAIT_A, byte discarded, overrun pulse.
- Operand outputs hold between frames. Only the capturing state overwrites each register.
- Counter width: clog2(TIMEOUT_CYCLES+1), minimum 1 bit; it never wraps.

Test Plan:
- Reset, then bytes 0x05, 0x03, 0x20; ALU stub returns a+b -> o_data_a=0x05, o_data_b=0x03, o_op=0x20; o_tx_data=0x08 with o_tx_start high exactly 1 cycle, 2 edges after the opcode tick; o_busy=1 until i_tx_done_tick.
- Two back-to-back frames (0xFF, 0x01, 0x20 then 0x0A, 0x02, 0x22), tx done pulsed between them -> two start pulses; o_tx_data=0x00 (8-bit wrap) then 0x08 (stub a-b).
- TIMEOUT_CYCLES=16; send 0x11, then idle 16 cycles -> o_timeout pulse on the 16th cycle after entering WAIT_B; state WAIT_A; the next byte 0x22 lands in o_data_a.
- TIMEOUT_CYCLES=16; the byte arrives on exactly the expiry cycle -> captured into o_data_b; no o_timeout.
- Send byte 0x77 during WAIT_TX -> o_rx_overrun 1-cycle pulse; o_data_a unchanged; the frame after tx done proceeds normally.
- Assert i_reset for 1 cycle in WAIT_OP and again in SEND -> all outputs 0 next cycle; state WAIT_A; no o_tx_start afterwards.

Source files
------------

// File: rtl/uart_alu_interface.sv
// Frames three UART bytes (A, B, opcode) into ALU operands and returns the ALU result to the UART transmitter.
// An inter-byte timeout abandons a stalled frame; bytes arriving while busy are dropped and flagged.
module uart_alu_interface #(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done_tick,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_rx_overrun
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic               overrun_q, overrun_d;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    overrun_d  = 1'b0;

    case (state_q)
      WAIT_A: begin
        cnt_d = '0;
        if (i_rx_done_tick) begin
          data_a_d = i_rx_data;
          state_d  = WAIT_B;
        end
      end
      WAIT_B, WAIT_OP: begin
        if (i_rx_done_tick) begin
          cnt_d = '0;
          if (state_q == WAIT_B) begin
            data_b_d = i_rx_data;
            state_d  = WAIT_OP;
          end else begin
            op_d    = i_rx_data[NB_OP-1:0];
            state_d = EXEC;
          end
        end else if (TO_EN) begin
          // A tick on the expiry cycle takes priority over the timeout.
          if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            timeout_d = 1'b1;
            state_d   = WAIT_A;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      EXEC: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        overrun_d  = i_rx_done_tick;
        state_d    = SEND;
      end
      SEND: begin
        overrun_d = i_rx_done_tick;
        state_d   = WAIT_TX;
      end
      WAIT_TX: begin
        overrun_d = i_rx_done_tick;
        if (i_tx_done_tick) begin
          state_d = WAIT_A;
        end
      end
      default: begin
        state_d = WAIT_A;
      end
    endcase

    busy_d = (state_d == EXEC) || (state_d == SEND) || (state_d == WAIT_TX);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= WAIT_A;
      cnt_q      <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_data_a     = data_a_q;
  assign o_data_b     = data_b_q;
  assign o_op         = op_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_start   = tx_start_q;
  assign o_busy       = busy_q;
  assign o_timeout    = timeout_q;
  assign o_rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Scoreboard bench for uart_alu_interface: the driver predicts each start/timeout/overrun event
// from frame-level rules and a monitor matches every DUT pulse against those predictions.
module tb_uart_alu_interface;

  localparam int unsigned NB_DATA = 8;
  localparam int unsigned NB_OP   = 6;
  localparam int unsigned TO      = 16;

  logic               clk = 1'b0;
  logic               i_reset;
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done_tick;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_tx_done_tick;
  logic [NB_DATA-1:0] o_data_a, o_data_b, o_tx_data;
  logic [NB_OP-1:0]   o_op;
  logic               o_tx_start, o_busy, o_timeout, o_rx_overrun;

  always #5 clk = ~clk;

  uart_alu_interface #(
    .NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done_tick(i_rx_done_tick),
    .i_alu_result(i_alu_result), .i_tx_done_tick(i_tx_done_tick),
    .o_data_a(o_data_a), .o_data_b(o_data_b), .o_op(o_op), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .o_busy(o_busy), .o_timeout(o_timeout), .o_rx_overrun(o_rx_overrun)
  );

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Combinational ALU stub driven by the DUT operand outputs.
  always_comb i_alu_result = alu_ref(o_data_a, o_data_b, o_op);

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] tx;
  } ev_t;

  ev_t  tx_q[$];
  ev_t  to_q[$];
  ev_t  ovr_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic exp_busy = 1'b0;
  bit   started = 1'b0;
  logic rst_seen = 1'b0;
  logic start_prev = 1'b0;
  logic [7:0] m_a = '0, m_b = '0;
  logic [5:0] m_op = '0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= i_reset;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic ev_t mk_ev(input int c);
    ev_t e;
    e.cyc = c;
    e.a   = m_a;
    e.b   = m_b;
    e.op  = m_op;
    e.tx  = alu_ref(m_a, m_b, m_op);
    return e;
  endfunction

  // Monitor: samples on the falling edge, pops predictions whenever the DUT pulses.
  always @(negedge clk) begin
    ev_t e;
    if (started) begin
      if (rst_seen) begin
        chk("rst_a", 32'(o_data_a), 0);
        chk("rst_b", 32'(o_data_b), 0);
        chk("rst_op", 32'(o_op), 0);
        chk("rst_tx_data", 32'(o_tx_data), 0);
        chk("rst_flags", {28'd0, o_tx_start, o_busy, o_timeout, o_rx_overrun}, 0);
      end
      chk("busy", 32'(o_busy), 32'(exp_busy));
      if (start_prev) chk("start_width", 32'(o_tx_start), 0);
      if (o_tx_start && !start_prev) begin
        if (tx_q.size() == 0) chk("spurious_start", 1, 0);
        else begin
          e = tx_q.pop_front();
          chk("start_cycle", cyc, e.cyc);
          chk("tx_data", 32'(o_tx_data), 32'(e.tx));
          chk("data_a", 32'(o_data_a), 32'(e.a));
          chk("data_b", 32'(o_data_b), 32'(e.b));
          chk("op", 32'(o_op), 32'(e.op));
        end
      end
      if (o_timeout) begin
        if (to_q.size() == 0) chk("spurious_timeout", 1, 0);
        else begin
          e = to_q.pop_front();
          chk("timeout_cycle", cyc, e.cyc);
          chk("timeout_hold_a", 32'(o_data_a), 32'(e.a));
          chk("timeout_hold_b", 32'(o_data_b), 32'(e.b));
          chk("timeout_hold_op", 32'(o_op), 32'(e.op));
        end
      end
      if (o_rx_overrun) begin
        if (ovr_q.size() == 0) chk("spurious_overrun", 1, 0);
        else begin
          e = ovr_q.pop_front();
          chk("overrun_cycle", cyc, e.cyc);
          chk("overrun_hold_a", 32'(o_data_a), 32'(e.a));
        end
      end
      start_prev = o_tx_start;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rx(input logic [7:0] b);
    i_rx_data      = b;
    i_rx_done_tick = 1'b1;
    step();
    i_rx_done_tick = 1'b0;
    i_rx_data      = 8'($urandom);
  endtask

  // One full frame; g1/g2 are edge distances between byte ticks (16 = tick on the expiry cycle).
  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                       input int g1, input int g2, input int wait_cyc,
                       input bit ovr, input bit simul, input logic [7:0] ob);
    rx(a);   m_a = a;
    idle(g1 - 1);
    rx(b);   m_b = b;
    idle(g2 - 1);
    rx(opb); m_op = opb[5:0];
    exp_busy = 1'b1;
    tx_q.push_back(mk_ev(cyc + 1));
    idle(2);
    for (int i = 0; i < wait_cyc; i++) begin
      if (ovr && i == 0) begin
        rx(ob);
        ovr_q.push_back(mk_ev(cyc));
      end else step();
    end
    i_tx_done_tick = 1'b1;
    if (simul) begin
      i_rx_data      = ob;
      i_rx_done_tick = 1'b1;
    end
    step();
    i_tx_done_tick = 1'b0;
    i_rx_done_tick = 1'b0;
    exp_busy = 1'b0;
    if (simul) ovr_q.push_back(mk_ev(cyc));
  endtask

  // Stall after A (or after A and B): frame abandoned TO edges after the last tick.
  task automatic to_frame(input logic [7:0] a, input logic [7:0] b, input bit in_op, input int g);
    rx(a); m_a = a;
    if (in_op) begin
      idle(g - 1);
      rx(b); m_b = b;
    end
    to_q.push_back(mk_ev(cyc + int'(TO)));
    idle(int'(TO));
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    m_a = '0; m_b = '0; m_op = '0;
    exp_busy = 1'b0;
  endtask

  function automatic logic [7:0] rand_op();
    logic [7:0] t;
    case ($urandom_range(0, 3))
      0: t = 8'h20;
      1: t = 8'h22;
      2: t = 8'hE4;
      default: t = 8'($urandom);
    endcase
    return t;
  endfunction

  initial begin
    i_reset = 1'b1; i_rx_data = '0; i_rx_done_tick = 1'b0; i_tx_done_tick = 1'b0;
    idle(3);
    i_reset = 1'b0;
    started = 1'b1;
    idle(2);

    frame(8'h05, 8'h03, 8'h20, 1, 1, 3, 0, 0, 8'h00);
    frame(8'hFF, 8'h01, 8'h20, 2, 1, 1, 0, 0, 8'h00);
    frame(8'h0A, 8'h02, 8'h22, 1, 3, 0, 0, 0, 8'h00);
    to_frame(8'h11, 8'h00, 0, 1);
    frame(8'h22, 8'h33, 8'h20, 1, 1, 2, 0, 0, 8'h00);
    frame(8'h40, 8'h41, 8'h24, 16, 16, 2, 0, 0, 8'h00);
    frame(8'h12, 8'h34, 8'h20, 1, 1, 3, 1, 0, 8'h77);
    frame(8'h56, 8'h21, 8'h22, 1, 1, 1, 0, 1, 8'h99);
    to_frame(8'h61, 8'h62, 1, 5);
    frame(8'h01, 8'h02, 8'h20, 1, 1, 1, 0, 0, 8'h00);

    i_rx_data = 8'hAA; rx(8'hAA); m_a = 8'hAA;
    rx(8'hBB); m_b = 8'hBB;
    do_reset();
    idle(3);
    rx(8'h31); m_a = 8'h31;
    rx(8'h32); m_b = 8'h32;
    rx(8'h20); m_op = 6'h20;
    exp_busy = 1'b1;
    tx_q.push_back(mk_ev(cyc + 1));
    step();
    do_reset();
    idle(6);
    frame(8'h07, 8'h08, 8'h22, 1, 1, 1, 0, 0, 8'h00);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        to_frame(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(1, 16)));
      end else begin
        int w;
        w = int'($urandom_range(0, 4));
        frame(8'($urandom), 8'($urandom), rand_op(),
              int'($urandom_range(1, 16)), int'($urandom_range(1, 16)), w,
              (w > 0) && ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0), 8'($urandom));
      end
      idle(int'($urandom_range(0, 3)));
    end

    idle(5);
    chk("tx_q_drained", tx_q.size(), 0);
    chk("to_q_drained", to_q.size(), 0);
    chk("ovr_q_drained", ovr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
